fx_sq_acc: RTL and testbench

Downstream consumer of the fixed-point subtract stage. It takes a stream of signed fixed-point differences, squares each one, and accumulates the squares over a block of i_len samples. It emits one sum-of-squared-error word per block through a valid/ready handshake. This is the error-energy stage of the PSR metric path, feeding the normalisation/log stage.

---
 rtl/fx_pkg.sv | 36 +++
 rtl/fx_square.sv | 56 +++++
 rtl/fx_sq_acc.sv | 166 ++++++++++++++++
 tb/tb_fx_sq_acc.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fx_pkg.sv
// -----------------------------------------------------------------------------
// fx_pkg
// Shared definitions for the fixed-point error-energy path: default widths,
// the block FSM state type and an unsigned saturating adder.
// -----------------------------------------------------------------------------
package fx_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned PROD_WIDTH     = 2 * DATA_WIDTH_DEF;
    // Widest accumulator the saturating adder supports.
    localparam int unsigned MAX_ACC_WIDTH  = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Unsigned add of two width-bit values (zero-extended to MAX_ACC_WIDTH).
    // On carry out of bit width-1 the result clamps to width ones and ovf is set.
    function automatic logic [MAX_ACC_WIDTH-1:0] sat_add_u(
        input  logic [MAX_ACC_WIDTH-1:0] a,
        input  logic [MAX_ACC_WIDTH-1:0] b,
        input  int unsigned              width,
        output logic                     ovf
    );
        logic [MAX_ACC_WIDTH:0]   sum;
        logic [MAX_ACC_WIDTH-1:0] ones;
        sum  = {1'b0, a} + {1'b0, b};
        ovf  = |(sum >> width);
        ones = {MAX_ACC_WIDTH{1'b1}} >> (MAX_ACC_WIDTH - width);
        return ovf ? ones : sum[MAX_ACC_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/fx_square.sv
// -----------------------------------------------------------------------------
// fx_square
// Registered signed squarer: o_sq = (i_data * i_data) >> FRAC_BITS, keeping
// the input Q format. One register stage; o_valid follows i_valid.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   i_valid      sample strobe
//   i_data       signed two's-complement sample
//   o_valid      registered strobe aligned with o_sq
//   o_sq         unsigned truncated square, 2*DATA_WIDTH-FRAC_BITS bits
// -----------------------------------------------------------------------------
module fx_square
    import fx_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter  int unsigned FRAC_BITS  = 16,
    localparam int unsigned SQ_WIDTH   = 2 * DATA_WIDTH - FRAC_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic [SQ_WIDTH-1:0]   o_sq
);

    localparam int unsigned PW = 2 * DATA_WIDTH;

    logic [PW-1:0]       ext_c;
    logic [PW-1:0]       prod_c;
    logic                valid_q, valid_d;
    logic [SQ_WIDTH-1:0] sq_q, sq_d;

    // Low PW bits of the sign-extended product are the exact square, since
    // |d|^2 <= 2^(PW-2) always fits.
    always_comb begin
        ext_c   = {{DATA_WIDTH{i_data[DATA_WIDTH-1]}}, i_data};
        prod_c  = ext_c * ext_c;
        sq_d    = SQ_WIDTH'(prod_c >> FRAC_BITS);
        valid_d = i_valid;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            sq_q    <= '0;
        end else begin
            valid_q <= valid_d;
            sq_q    <= sq_d;
        end
    end

    assign o_valid = valid_q;
    assign o_sq    = sq_q;

endmodule

// File: rtl/fx_sq_acc.sv
// -----------------------------------------------------------------------------
// fx_sq_acc
// Sum-of-squared-error over blocks of i_len samples. Each accepted sample is
// squared (fx_square), accumulated with saturation, and one result per block
// is offered on a valid/ready handshake.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   i_len              block length, latched on the first beat (0 means 1)
//   i_valid, i_data    sample stream, accepted when i_valid && o_ready
//   o_ready            block can take a sample this cycle
//   o_valid, i_ready   result handshake
//   o_sum, o_sat       block sum (input Q format) and saturation flag
// -----------------------------------------------------------------------------
module fx_sq_acc
    import fx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned FRAC_BITS  = 16,
    parameter int unsigned ACC_WIDTH  = PROD_WIDTH,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CNT_WIDTH-1:0]  i_len,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ready,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [ACC_WIDTH-1:0]  o_sum,
    output logic                  o_sat
);

    localparam int unsigned SQ_WIDTH = 2 * DATA_WIDTH - FRAC_BITS;

    // Accumulator must hold at least one full square.
    if (ACC_WIDTH < SQ_WIDTH || ACC_WIDTH > MAX_ACC_WIDTH) begin : g_width_chk
        $error("fx_sq_acc: ACC_WIDTH out of range for DATA_WIDTH/FRAC_BITS");
    end

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] len_q, len_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] len_eff_c;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 sat_q, sat_d;
    logic                 ready_q, ready_d;
    logic                 valid_q, valid_d;
    logic [ACC_WIDTH-1:0] sum_q, sum_d;
    logic                 osat_q, osat_d;
    logic                 ovf_c;
    logic                 beat_c;
    logic                 ack_c;
    logic                 sq_valid;
    logic [SQ_WIDTH-1:0]  sq;

    assign beat_c = i_valid && ready_q;
    assign ack_c  = (state_q == DONE) && valid_q && i_ready;

    fx_square #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS)
    ) u_square (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (beat_c),
        .i_data  (i_data),
        .o_valid (sq_valid),
        .o_sq    (sq)
    );

    // State register and block bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: count beats, drain the squarer, hold the result until taken.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        len_eff_c = (i_len == '0) ? CNT_WIDTH'(1) : i_len;
        case (state_q)
            IDLE: begin
                if (beat_c) begin
                    len_d   = len_eff_c;
                    cnt_d   = CNT_WIDTH'(1);
                    state_d = (len_eff_c == CNT_WIDTH'(1)) ? DRAIN : ACC;
                end
            end
            ACC: begin
                if (beat_c) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                    if (cnt_d == len_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: state_d = DONE;
            DONE: begin
                if (ack_c) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered outputs. The result registers load on the
    // first DONE cycle, when the last square has landed in acc_q.
    always_comb begin
        acc_d   = acc_q;
        sat_d   = sat_q;
        ovf_c   = 1'b0;
        sum_d   = sum_q;
        osat_d  = osat_q;
        if (sq_valid) begin
            acc_d = ACC_WIDTH'(sat_add_u(MAX_ACC_WIDTH'(acc_q), MAX_ACC_WIDTH'(sq),
                                         ACC_WIDTH, ovf_c));
            sat_d = sat_q | ovf_c;
        end
        if (ack_c) begin
            acc_d = '0;
            sat_d = 1'b0;
        end
        if ((state_q == DONE) && !valid_q) begin
            sum_d  = acc_q;
            osat_d = sat_q;
        end
        valid_d = (state_q == DONE) && !ack_c;
        ready_d = (state_d == IDLE) || (state_d == ACC);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q   <= '0;
            sat_q   <= 1'b0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            sum_q   <= '0;
            osat_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            sat_q   <= sat_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            sum_q   <= sum_d;
            osat_q  <= osat_d;
        end
    end

    assign o_ready = ready_q;
    assign o_valid = valid_q;
    assign o_sum   = sum_q;
    assign o_sat   = osat_q;

endmodule

// File: tb/tb_fx_sq_acc.sv
// -----------------------------------------------------------------------------
// tb_fx_sq_acc
// Drives two instances (64-bit and 48-bit accumulators) with the same block
// stream and compares each result against sums computed with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_fx_sq_acc;

    typedef struct {
        logic [63:0] s64;
        logic        sat64;
        logic [47:0] s48;
        logic        sat48;
        int          last_cyc;
        int          hold;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] i_len;
    logic        i_valid;
    logic [31:0] i_data;
    logic        i_ready;
    logic        o_ready_a, o_valid_a, o_sat_a;
    logic [63:0] o_sum_a;
    logic        o_ready_b, o_valid_b, o_sat_b;
    logic [47:0] o_sum_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    exp_t        exp_q[$];
    logic [31:0] blk[64];

    fx_sq_acc u_dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_len   (i_len),
        .i_valid (i_valid),
        .i_data  (i_data),
        .o_ready (o_ready_a),
        .o_valid (o_valid_a),
        .i_ready (i_ready),
        .o_sum   (o_sum_a),
        .o_sat   (o_sat_a)
    );

    fx_sq_acc #(.ACC_WIDTH(48)) u_dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_len   (i_len),
        .i_valid (i_valid),
        .i_data  (i_data),
        .o_ready (o_ready_b),
        .o_valid (o_valid_b),
        .i_ready (i_ready),
        .o_sum   (o_sum_b),
        .o_sat   (o_sat_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Square of a Q16.16 value, truncated back to Q16.16.
    function automatic logic [127:0] sq_ref(input logic [31:0] d);
        longint      dl;
        logic [127:0] p;
        dl = longint'(signed'(d));
        p  = 128'(dl * dl);
        return p >> 16;
    endfunction

    function automatic logic [127:0] sat_ref(input logic [127:0] tot, input int w, output logic s);
        logic [127:0] mx;
        mx = (128'(1) << w) - 128'(1);
        s  = (tot > mx);
        return s ? mx : tot;
    endfunction

    // Send one block of blk[0..n-1]; new_len >= 0 rewrites i_len after the first beat.
    task automatic send_block(input int len_field, input int gap_max, input int hold, input int new_len);
        int n, w, g;
        logic [127:0] tot, r;
        logic s;
        exp_t e;
        n   = (len_field == 0) ? 1 : len_field;
        tot = '0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
                for (int k = 0; k < g; k++) begin
                    i_valid = 1'b0;
                    i_data  = $urandom;
                    chk("ready_gap", 128'(o_ready_a), 1);
                    @(negedge clk);
                end
            end
            i_valid = 1'b1;
            i_data  = blk[i];
            if (i == 0) begin
                i_len = 16'(len_field);
                w = 0;
                while (!o_ready_a && w < 100) begin
                    @(negedge clk);
                    w++;
                end
                if (w >= 100) chk("ready_timeout", 128'(o_ready_a), 1);
            end else begin
                chk("ready_blk", 128'(o_ready_a), 1);
            end
            tot = tot + sq_ref(blk[i]);
            if (i == n - 1) begin
                r          = sat_ref(tot, 64, s);
                e.s64      = r[63:0];
                e.sat64    = s;
                r          = sat_ref(tot, 48, s);
                e.s48      = r[47:0];
                e.sat48    = s;
                e.last_cyc = cyc + 1;
                e.hold     = hold;
                exp_q.push_back(e);
            end
            @(negedge clk);
            if (i == 0 && new_len >= 0) i_len = 16'(new_len);
        end
        i_valid = 1'b0;
        i_data  = $urandom;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || o_valid_a) && w < 300) begin
            @(negedge clk);
            w++;
        end
        chk("drain_timeout", 128'(exp_q.size()), 0);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_data();
        case ($urandom_range(3, 0))
            0: return 32'($signed(20'($urandom)));
            1: return $urandom;
            2: return 32'h8000_0000;
            default: return 32'h7FFF_FFFF - 32'($urandom_range(255, 0));
        endcase
    endfunction

    // Result monitor: checks each result against the queue and drives i_ready.
    initial begin : monitor
        logic prev, ack;
        int   hold_left;
        exp_t e;
        prev      = 1'b0;
        ack       = 1'b0;
        hold_left = 0;
        i_ready   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 1'b0;
                ack  = 1'b0;
                continue;
            end
            if (ack) begin
                chk("valid_drop", 128'(o_valid_a), 0);
                chk("ready_after_ack", 128'(o_ready_a), 1);
                ack = 1'b0;
            end else if (o_valid_a) begin
                if (!prev) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_valid", 128'(o_valid_a), 0);
                        hold_left = 0;
                    end else begin
                        e = exp_q[0];
                        chk("sum64", 128'(o_sum_a), 128'(e.s64));
                        chk("sat64", 128'(o_sat_a), 128'(e.sat64));
                        chk("valid48", 128'(o_valid_b), 1);
                        chk("sum48", 128'(o_sum_b), 128'(e.s48));
                        chk("sat48", 128'(o_sat_b), 128'(e.sat48));
                        chk("latency", 128'(cyc - e.last_cyc), 2);
                        hold_left = e.hold;
                    end
                end else if (exp_q.size() != 0) begin
                    chk("hold_sum64", 128'(o_sum_a), 128'(exp_q[0].s64));
                    chk("hold_sat64", 128'(o_sat_a), 128'(exp_q[0].sat64));
                    chk("hold_sum48", 128'(o_sum_b), 128'(exp_q[0].s48));
                end
                chk("ready_in_done", 128'(o_ready_a), 0);
                if (hold_left > 0) begin
                    i_ready = 1'b0;
                    hold_left--;
                end else begin
                    i_ready = 1'b1;
                    ack     = 1'b1;
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end
            end else begin
                i_ready = 1'($urandom_range(1, 0));
            end
            prev = o_valid_a;
        end
    end

    initial begin : driver
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        i_len   = 16'd4;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 128'(o_ready_a), 0);
        chk("rst_valid", 128'(o_valid_a), 0);
        chk("rst_sum", 128'(o_sum_a), 0);
        chk("rst_sat", 128'(o_sat_a), 0);
        chk("rst_valid48", 128'(o_valid_b), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 128'(o_ready_a), 1);

        // Back-to-back block of four.
        blk[0] = 32'h0001_0000; blk[1] = 32'hFFFF_0000;
        blk[2] = 32'h0002_0000; blk[3] = 32'h0000_0000;
        send_block(4, 0, 0, -1);
        wait_idle();
        // Same stream with idle gaps and i_len rewritten mid-block.
        send_block(4, 1, 0, 9);
        wait_idle();
        // Result held by downstream for five cycles.
        send_block(4, 0, 5, -1);
        wait_idle();
        // Saturation in the 48-bit accumulator, then a clean block.
        for (int i = 0; i < 4; i++) blk[i] = 32'h8000_0000;
        send_block(4, 0, 0, -1);
        blk[0] = 32'h0001_0000;
        send_block(1, 0, 2, -1);
        wait_idle();
        // Length zero behaves as length one.
        blk[0] = 32'h0003_0000;
        send_block(0, 0, 0, -1);
        wait_idle();

        // Reset after two of four beats discards the partial block.
        i_len = 16'd4;
        for (int i = 0; i < 2; i++) begin
            i_valid = 1'b1;
            i_data  = 32'h7FFF_0000;
            chk("abort_ready", 128'(o_ready_a), 1);
            @(negedge clk);
        end
        i_valid = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        chk("abort_rst_ready", 128'(o_ready_a), 0);
        chk("abort_rst_valid", 128'(o_valid_a), 0);
        chk("abort_rst_ready48", 128'(o_ready_b), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready_after", 128'(o_ready_a), 1);
        blk[0] = 32'h0001_0000; blk[1] = 32'h0001_0000;
        send_block(2, 0, 0, -1);
        wait_idle();

        // Random blocks.
        for (int b = 0; b < 40; b++) begin
            int len_field;
            len_field = int'($urandom_range(8, 0));
            for (int i = 0; i < 8; i++) blk[i] = rand_data();
            send_block(len_field, int'($urandom_range(2, 0)), int'($urandom_range(3, 0)),
                       ($urandom_range(1, 0) == 1) ? int'($urandom_range(65535, 0)) : -1);
        end
        wait_idle();
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
